// File: rtl/sw_x_loader.sv
// Double-buffered loader for the Smith-Waterman reference sequence X.
// A shadow bank fills from the host stream; it is copied to the live bank only while lock is low.
module sw_x_loader #(
    parameter int SEQ_DEPTH = 50
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            wr_data,
    input  logic                   wr_en,
    output logic                   wr_full,
    input  logic                   stream_open,
    input  logic                   lock,
    output logic [2*SEQ_DEPTH-1:0] seq_x,
    output logic                   x_valid,
    output logic [7:0]             x_gen,
    output logic                   load_err
);

    localparam int WORDS = (SEQ_DEPTH + 15) / 16;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int XW    = 2 * SEQ_DEPTH;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT,
        READY
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            open_q, open_d;
    logic            rise_q, rise_d;
    logic [XW-1:0]   shadow_q, shadow_d;
    logic [XW-1:0]   seq_q, seq_d;
    logic            valid_q, valid_d;
    logic [7:0]      gen_q, gen_d;
    logic            err_q, err_d;
    int              idx;

    assign wr_full  = (state_q == IDLE) || (state_q == COMMIT);
    assign seq_x    = seq_q;
    assign x_valid  = valid_q;
    assign x_gen    = gen_q;
    assign load_err = err_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        seq_d    = seq_q;
        valid_d  = valid_q;
        gen_d    = gen_q;
        err_d    = err_q;
        idx      = 0;
        // Edge detect is registered so the FSM acts one cycle after the open.
        open_d   = stream_open;
        rise_d   = stream_open && !open_q;

        unique case (state_q)
            IDLE: begin
                if (rise_q) begin
                    shadow_d = '0;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (wr_en) begin
                    for (int k = 0; k < 16; k++) begin
                        idx = 16 * int'(cnt_q) + k;
                        if (idx < SEQ_DEPTH) begin
                            shadow_d[2*idx +: 2] = wr_data[2*k +: 2];
                        end
                    end
                    cnt_d = cnt_q + CW'(1);
                end
                // A final word in the closing cycle still completes the load.
                if (wr_en && (cnt_q == LAST)) begin
                    state_d = COMMIT;
                end else if (!stream_open) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                if (!lock) begin
                    seq_d   = shadow_q;
                    valid_d = 1'b1;
                    gen_d   = gen_q + 8'd1;
                    state_d = READY;
                end
            end
            READY: begin
                if (wr_en) begin
                    err_d = 1'b1;
                end
                if (!stream_open) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            open_q   <= 1'b0;
            rise_q   <= 1'b0;
            shadow_q <= '0;
            seq_q    <= '0;
            valid_q  <= 1'b0;
            gen_q    <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            open_q   <= open_d;
            rise_q   <= rise_d;
            shadow_q <= shadow_d;
            seq_q    <= seq_d;
            valid_q  <= valid_d;
            gen_q    <= gen_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_sw_x_loader.sv
// Directed bench for sw_x_loader: load, lock-held commit, abort,
// overflow, close-with-final-word and mid-load reset.
module tb_sw_x_loader;

    logic        clk;
    logic        rst_n;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        wr_full;
    logic        stream_open;
    logic        lock;
    logic [99:0] seq_x;
    logic        x_valid;
    logic [7:0]  x_gen;
    logic        load_err;

    int nchk  = 0;
    int nfail = 0;
    logic [31:0] wq [6];

    sw_x_loader #(.SEQ_DEPTH(50)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .wr_full     (wr_full),
        .stream_open (stream_open),
        .lock        (lock),
        .seq_x       (seq_x),
        .x_valid     (x_valid),
        .x_gen       (x_gen),
        .load_err    (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [99:0] got,
                       input logic [99:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Host-side writer: holds each word until it is accepted.
    task automatic push(input int n);
        int i;
        int g;
        logic acc;
        i = 0;
        g = 0;
        while (i < n && g < 50) begin
            wr_en   = 1'b1;
            wr_data = wq[i];
            acc     = !wr_full;
            tick();
            if (acc) i++;
            g++;
        end
        wr_en = 1'b0;
        chk("push_cnt", 100'(i), 100'(n));
    endtask

    task automatic open_stream;
        stream_open = 1'b1;
        tick();
        chk("open_full1", 100'(wr_full), 100'd1);
        tick();
        chk("open_full0", 100'(wr_full), 100'd0);
    endtask

    localparam logic [99:0] SEQ_A = 100'hB_1B1B1B1B_1B1B1B1B_1B1B1B1B;
    localparam logic [99:0] SEQ_B = 100'h5_12345678_0000FFFF_E4E4E4E4;
    localparam logic [99:0] SEQ_D = 100'hA_33333333_22222222_11111111;
    localparam logic [99:0] SEQ_E = 100'hD_DEADBEEF_89ABCDEF_01234567;
    localparam logic [99:0] SEQ_F = 100'hC_A5A5A5A5_F0F0F0F0_0F0F0F0F;

    initial begin
        rst_n       = 1'b0;
        wr_data     = '0;
        wr_en       = 1'b0;
        stream_open = 1'b0;
        lock        = 1'b0;
        tick();
        tick();
        chk("rst_seq", seq_x, 100'd0);
        chk("rst_valid", 100'(x_valid), 100'd0);
        chk("rst_gen", 100'(x_gen), 100'd0);
        chk("rst_err", 100'(load_err), 100'd0);
        chk("rst_full", 100'(wr_full), 100'd1);
        rst_n = 1'b1;
        tick();
        chk("idle_full", 100'(wr_full), 100'd1);

        // Basic load
        for (int i = 0; i < 4; i++) wq[i] = 32'h1B1B1B1B;
        open_stream();
        push(4);
        chk("a_commit_full", 100'(wr_full), 100'd1);
        chk("a_pre_valid", 100'(x_valid), 100'd0);
        tick();
        chk("a_seq", seq_x, SEQ_A);
        chk("a_low", 100'(seq_x[7:0]), 100'h1B);
        chk("a_sym48_49", 100'(seq_x[99:96]), 100'hB);
        chk("a_valid", 100'(x_valid), 100'd1);
        chk("a_gen", 100'(x_gen), 100'd1);
        chk("a_err", 100'(load_err), 100'd0);
        chk("a_ready_full", 100'(wr_full), 100'd0);
        stream_open = 1'b0;
        tick();
        chk("a_close_full", 100'(wr_full), 100'd1);

        // Commit held off by lock; a close during the hold does not abort
        wq[0] = 32'hE4E4E4E4;
        wq[1] = 32'h0000FFFF;
        wq[2] = 32'h12345678;
        wq[3] = 32'hFFFFFFF5;
        lock  = 1'b1;
        open_stream();
        push(4);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) stream_open = 1'b0;
            tick();
            chk("lk_full", 100'(wr_full), 100'd1);
            chk("lk_seq", seq_x, SEQ_A);
        end
        lock = 1'b0;
        tick();
        chk("b_seq", seq_x, SEQ_B);
        chk("b_gen", 100'(x_gen), 100'd2);
        chk("b_err", 100'(load_err), 100'd0);
        chk("b_full", 100'(wr_full), 100'd0);
        tick();
        chk("b_idle_full", 100'(wr_full), 100'd1);

        // Aborted load
        wq[0] = 32'h99999999;
        wq[1] = 32'h77777777;
        open_stream();
        push(2);
        stream_open = 1'b0;
        tick();
        chk("ab_err", 100'(load_err), 100'd1);
        chk("ab_seq", seq_x, SEQ_B);
        chk("ab_gen", 100'(x_gen), 100'd2);
        chk("ab_full", 100'(wr_full), 100'd1);
        chk("ab_valid", 100'(x_valid), 100'd1);
        stream_open = 1'b1;
        tick();
        chk("ab_err_hold", 100'(load_err), 100'd1);
        tick();
        chk("ab_err_clr", 100'(load_err), 100'd0);
        chk("ab_reload", 100'(wr_full), 100'd0);

        // Overflow: words 5 and 6 land in READY and are dropped
        wq[0] = 32'h11111111;
        wq[1] = 32'h22222222;
        wq[2] = 32'h33333333;
        wq[3] = 32'h4444444A;
        wq[4] = 32'hAAAAAAAA;
        wq[5] = 32'h55555555;
        push(6);
        chk("ov_err", 100'(load_err), 100'd1);
        chk("ov_seq", seq_x, SEQ_D);
        chk("ov_gen", 100'(x_gen), 100'd3);
        chk("ov_full", 100'(wr_full), 100'd0);
        stream_open = 1'b0;
        tick();
        chk("ov_idle", 100'(wr_full), 100'd1);

        // Close in the same cycle as the final word
        wq[0] = 32'h01234567;
        wq[1] = 32'h89ABCDEF;
        wq[2] = 32'hDEADBEEF;
        open_stream();
        push(3);
        wr_en       = 1'b1;
        wr_data     = 32'hCAFEF00D;
        stream_open = 1'b0;
        tick();
        wr_en = 1'b0;
        chk("cc_full", 100'(wr_full), 100'd1);
        chk("cc_err", 100'(load_err), 100'd0);
        tick();
        chk("cc_seq", seq_x, SEQ_E);
        chk("cc_gen", 100'(x_gen), 100'd4);
        chk("cc_err2", 100'(load_err), 100'd0);

        // Reset mid-load with open held high
        tick();
        wq[0] = 32'h0F0F0F0F;
        wq[1] = 32'hF0F0F0F0;
        open_stream();
        push(2);
        rst_n = 1'b0;
        tick();
        chk("mr_seq", seq_x, 100'd0);
        chk("mr_valid", 100'(x_valid), 100'd0);
        chk("mr_gen", 100'(x_gen), 100'd0);
        chk("mr_err", 100'(load_err), 100'd0);
        chk("mr_full", 100'(wr_full), 100'd1);
        rst_n = 1'b1;
        tick();
        chk("mr_rise_full", 100'(wr_full), 100'd1);
        tick();
        chk("mr_load_full", 100'(wr_full), 100'd0);
        wq[2] = 32'hA5A5A5A5;
        wq[3] = 32'h5A5A5A5C;
        push(4);
        tick();
        chk("mr_seq2", seq_x, SEQ_F);
        chk("mr_gen2", 100'(x_gen), 100'd1);
        chk("mr_valid2", 100'(x_valid), 100'd1);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/sw_x_loader.md
# sw_x_loader

Loads the Smith-Waterman reference sequence X from the host stream `/dev/xillybus_stream_dna_x` into a double-buffered register bank that drives the `X_i` inputs of the `sw_pe` array. It sits directly upstream of the PE array, beside the Y-stream shifter, and replaces the hard-wired X constant. A new sequence is assembled in a shadow bank. It is committed atomically to the live bank only while the array is not busy, so a running comparison never sees a partially updated X.

## Interface

- `SEQ_DEPTH`, 50, number of PEs and number of 2-bit X symbols.
- `WORDS`, derived as ceil(SEQ_DEPTH/16) (4 for the default), is the number of 32-bit words per sequence. It is a localparam, not overridable.
- `clk`  in  1  `bus_clk` domain; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `wr_data`  in  32  `user_w_stream_dna_x_data`.
- `wr_en`  in  1  `user_w_stream_dna_x_wren`.
- `wr_full`  out  1  to `user_w_stream_dna_x_full`.
- `stream_open`  in  1  `user_w_stream_dna_x_open`.
- `lock`  in  1  high while the PE array is processing; blocks commit.
- `seq_x`  out  2*SEQ_DEPTH  live X bank; symbol i on bits [2i+1:2i].
- `x_valid`  out  1  live bank holds a completely loaded sequence.
- `x_gen`  out  8  commit counter, incremented on every commit and wrapping 255→0.
- `load_err`  out  1  sticky error: aborted load or overflow word.

## Operation

- **State machine** (registered): IDLE, LOAD, COMMIT, READY.
- **Open edge detect**: `open_q` registers `stream_open`; rise = `stream_open && !open_q`.
- **Accepted write**: `wr_en && !wr_full`.
- **`wr_full`**: a decode of the state register only (1 in IDLE and COMMIT, 0 in LOAD and READY). No combinational path from inputs.
- **Packing**: bits [2k+1:2k] of word w hold symbol 16w+k. Symbols with index ≥ SEQ_DEPTH in the last word are discarded.
- **IDLE**:
  - On rise: clear shadow to 0, set word_cnt=0, clear `load_err`, go to LOAD.
  - Writes are refused (full=1).
- **LOAD**:
  - Each accepted word writes its 16 symbols into shadow at word_cnt and increments word_cnt.
  - Accepting word WORDS-1 moves to COMMIT.
  - If `stream_open`=0 with fewer than WORDS words accepted: set `load_err`, go to IDLE. Shadow is discarded and the live bank is unchanged.
  - Write and close in the same cycle: the write is accepted first. If that write is the final word, go to COMMIT and raise no error; otherwise abort as above.
- **COMMIT**:
  - full=1. Each cycle, if `lock`=0: `seq_x` ← shadow, `x_valid` ← 1, `x_gen` ← `x_gen`+1, go to READY.
  - If `lock`=1: hold indefinitely. A close here does not abort; the commit still happens.
- **READY**:
  - full=0. Extra accepted words are discarded and set `load_err`.
  - `stream_open`=0 goes to IDLE.
  - A rise is impossible in READY; reopening passes through IDLE.
- **`x_valid`**: once set, stays 1 until reset. A reload keeps the previous live sequence usable until the new commit.
- **Reset** (rst_n=0 at an edge), including mid-load:
  - state=IDLE, word_cnt=0, `open_q`=0, shadow=0.
  - Outputs: `seq_x`=0, `x_valid`=0, `x_gen`=0, `load_err`=0, `wr_full`=1.
  - If `stream_open` is already high when reset is released, the first cycle after release counts as a rise.

## Timing

- All outputs are registered or state decodes, and change only at posedge `clk`.
- **Commit latency**: final word accepted at edge N puts state in COMMIT after N. With `lock`=0 sampled at edge N+1, `seq_x`/`x_valid`/`x_gen` update at N+1 and `wr_full` returns to 0 after N+1.
- **Commit under lock**: if `lock` falls, the commit occurs at the first edge where `lock`=0 is sampled.
- **Open to load**: a rise seen at edge M gives state LOAD and `wr_full`=0 after M+1. The edge detector costs one cycle.
- **Throughput**: one word per cycle in LOAD, so a full load takes WORDS cycles back-to-back.

## Test plan

- **Basic load**: reset, open, write 4 words 0x1B1B1B1B (symbols 3,2,1,0 repeating), lock=0.
  - `seq_x`[7:0]=0x1B at 2 cycles after the last write.
  - Symbols 48..49 = 3,2; bits of word 3 above symbol 49 are ignored.
  - `x_valid`=1, `x_gen`=1, `load_err`=0.
- **Commit under lock**: hold lock=1 through the last word.
  - `wr_full`=1 and `seq_x` unchanged for 20 cycles.
  - Lower lock: commit at the first edge lock=0 is sampled.
- **Aborted load**: after a successful load A, reopen, write 2 words, close.
  - `load_err`=1, `seq_x` still A, `x_gen` unchanged, state IDLE.
  - Next reopen clears `load_err`.
- **Overflow**: write 6 words.
  - Words 5–6 are discarded and `load_err`=1.
  - `seq_x` reflects words 1–4.
- **Close coincident with final word**: `wr_en` on word 4 and `stream_open`=0 in the same cycle.
  - Commit occurs, `load_err`=0.
- **Reset mid-load**: assert rst_n=0 after 2 words.
  - All outputs return to reset values, `wr_full`=1.
  - With open held high, loading restarts from word 0 one cycle after release.
